// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder with valid/ready handshakes; define SERIAL_ADDER_SUB_EN for subtract support
module serial_adder_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data_a,
  input  logic [WIDTH-1:0] i_data_b,
  input  logic             i_carry,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_carry,
  output logic             o_busy
`ifdef SERIAL_ADDER_SUB_EN
  ,
  input  logic             i_sub
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] sh_a, sh_b, res, res_next;
  logic [CW-1:0] cnt;
  logic cy, sub, h1_s, h1_c, h2_s, h2_c, cy_next, last;
`ifdef SERIAL_ADDER_SUB_EN
  assign sub = i_sub;
`else
  assign sub = 1'b0;
`endif
  // one-bit slice: two half adders and an OR for the carry
  always_comb begin
    h1_s = sh_a[0] ^ sh_b[0];
    h1_c = sh_a[0] & sh_b[0];
    h2_s = h1_s ^ cy;
    h2_c = h1_s & cy;
    cy_next = h1_c | h2_c;
    res_next = WIDTH'({h2_s, res} >> 1);
    last = cnt == CW'(WIDTH - 1);
  end
  // control FSM with registered handshake outputs and result
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_busy <= 1'b0;
      o_data <= '0;
      o_carry <= 1'b0;
      sh_a <= '0;
      sh_b <= '0;
      res <= '0;
      cy <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (i_valid && o_ready) begin
          sh_a <= i_data_a;
          sh_b <= i_data_b ^ {WIDTH{sub}};
          cy <= sub | i_carry;
          res <= '0;
          cnt <= '0;
          state <= RUN;
          o_ready <= 1'b0;
          o_busy <= 1'b1;
        end
        RUN: begin
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          res <= res_next;
          cy <= cy_next;
          cnt <= cnt + CW'(1);
          if (last) begin
            state <= DONE;
            o_valid <= 1'b1;
            o_data <= res_next;
            o_carry <= cy_next;
          end
        end
        DONE: if (i_ready) begin
          state <= IDLE;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller that reuses one 1-bit add slice for a full WIDTH-bit addition. The slice is two half adders plus an OR for carry. One bit is processed per clock, LSB first, with the carry held in a flip-flop between bits. Sits beside the ALU as a low-area add path, with a valid/ready handshake on both operand input and result output.

Parameters:
WIDTH, 32, operand/result width in bits; legal range 1..64.

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst  input  1  synchronous active-high reset
i_valid  input  1  operand request valid
o_ready  output  1  controller can accept operands (IDLE only)
i_data_a  input  WIDTH  operand A
i_data_b  input  WIDTH  operand B
i_carry  input  1  carry-in for bit 0
o_valid  output  1  result valid
i_ready  input  1  consumer accepts result
o_data  output  WIDTH  sum
o_carry  output  1  carry-out of bit WIDTH-1
o_busy  output  1  high in RUN or DONE

Behaviour:
- Reset: synchronous, active-high, sampled on the i_clk rising edge.
  - Reset values: state=IDLE, o_ready=1, o_valid=0, o_busy=0, o_data=0, o_carry=0.
  - Internal shift registers, carry FF and bit counter are cleared.
  - i_rst during RUN or DONE aborts the operation; the partial result is discarded and nothing is emitted.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid & o_ready: load shA=i_data_a, shB=i_data_b, cy=i_carry, res=0, cnt=0; next state RUN.
  - i_valid low: remain in IDLE.
- RUN (one bit per cycle):
  - Slice: h1_s=shA[0]^shB[0], h1_c=shA[0]&shB[0]; h2_s=h1_s^cy, h2_c=h1_s&cy; bit=h2_s; cy_next=h1_c|h2_c.
  - res shifts right with bit entering at MSB; shA and shB shift right (zero fill); cy<=cy_next; cnt<=cnt+1.
  - When cnt==WIDTH-1: that bit is the last one; next state DONE.
  - Counter width is $clog2(WIDTH+1); no wrap occurs.
- DONE:
  - o_valid=1, o_data=res, o_carry=cy.
  - Outputs stay stable until o_valid & i_ready; then next state IDLE.
  - No timeout.
- Latency and throughput:
  - Accept edge at cycle 0; o_valid is high starting at cycle WIDTH+1 (WIDTH cycles in RUN).
  - Best-case throughput is one operation per WIDTH+2 cycles.
- Input handling outside IDLE: i_valid, i_data_a, i_data_b and i_carry are ignored; operands are captured only at the accept edge.
- o_data and o_carry hold their last result after the IDLE return until the next DONE; consumers must qualify them with o_valid.
- WIDTH=1: RUN lasts exactly one cycle.
- Simultaneous i_rst with any handshake: reset wins.

Optional Feature:
Macro SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port i_sub (1 bit), sampled at the accept edge.
  - When i_sub=1: shB loads ~i_data_b and cy loads 1; i_carry is ignored.
  - o_carry is then the not-borrow flag (1 means A>=B unsigned).
- Not defined: no i_sub port; the block is add-only.

Test Plan:
- WIDTH=8, A=0x0F, B=0x01, cin=0, i_ready=1 -> o_valid at cycle 9, o_data=0x10, o_carry=0, then o_ready=1 one cycle later.
- WIDTH=8, A=0xFF, B=0x01, cin=0 -> o_data=0x00, o_carry=1; then A=0xFF, B=0xFF, cin=1 -> o_data=0xFF, o_carry=1.
- Backpressure: i_ready=0 for 5 cycles in DONE -> o_valid stays 1, o_data/o_carry stable, o_ready=0; i_valid pulses with A=0x55 during this window are ignored.
- Reset mid-op: assert i_rst at RUN cycle 3 -> next cycle state IDLE, o_ready=1, o_valid=0, o_data=0; a new request A=0x02, B=0x03 then yields 0x05.
- WIDTH=1: A=1, B=1, cin=1 -> o_data=1, o_carry=1 with o_valid at cycle 2.
- SERIAL_ADDER_SUB_EN, WIDTH=8: A=0x05, B=0x07, i_sub=1 -> o_data=0xFE, o_carry=0; A=0x07, B=0x05 -> o_data=0x02, o_carry=1.
